// File: rtl/huffman_pkg.sv
// Shared types for the Huffman encoder back end: packer FSM states and the
// default-width FIFO entry layout.
package huffman_pkg;

  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_NBITS_W   = $clog2(DEF_BIT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pack_state_e;

  // One buffered packed word at the default width.
  typedef struct packed {
    logic [DEF_BIT_WIDTH-1:0] word;
    logic                     last;
    logic [DEF_NBITS_W-1:0]   nbits;
  } pack_entry_t;

endpackage

// File: rtl/huffman_word_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented whenever the FIFO
// is not empty. DEPTH must be a power of two so the pointers wrap naturally.
module huffman_word_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs the serial MSB-first code-bit stream into BIT_WIDTH-bit words,
// buffers them in a show-ahead FIFO and zero-pads the final partial word.
// Optional feature macro: HUFF_PACK_STATS_EN adds the total_bits_o counter.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             bit_valid_i,
  input  logic                             bit_i,
  input  logic                             last_i,
  output logic                             ready_o,
  output logic                             word_valid_o,
  output logic [BIT_WIDTH-1:0]             word_o,
  output logic                             word_last_o,
  output logic [$clog2(BIT_WIDTH+1)-1:0]   word_nbits_o,
  input  logic                             word_ready_i,
  output logic                             busy_o,
  output logic                             done_o
`ifdef HUFF_PACK_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]             total_bits_o
`endif
);

  localparam int FW = $clog2(BIT_WIDTH);
  localparam int NW = $clog2(BIT_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = BIT_WIDTH + 1 + NW;
  localparam logic [FW-1:0] FILL_MAX = FW'(BIT_WIDTH - 1);

  typedef struct packed {
    logic [BIT_WIDTH-1:0] word;
    logic                 last;
    logic [NW-1:0]        nbits;
  } entry_t;

  pack_state_e          state, state_nxt;
  logic [FW-1:0]        fill;
  logic [BIT_WIDTH-1:0] sreg;
  logic [BIT_WIDTH-1:0] wnext;
  logic                 accept;
  logic                 push;
  logic                 pop;
  entry_t               push_ent;
  entry_t               head_ent;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [AW:0]          fifo_count;

  assign accept = bit_valid_i && ready_o;
  // A word leaves the shifter when it is full or the stream ends.
  assign push   = accept && ((fill == FILL_MAX) || last_i);
  assign pop    = !fifo_empty && word_ready_i;
  // Unfilled low bits of sreg are always zero, which gives the padding.
  assign wnext  = sreg | (BIT_WIDTH'(bit_i) << (FILL_MAX - fill));

  // Entry formed from the word including the bit accepted this cycle.
  always_comb begin
    push_ent.word  = wnext;
    push_ent.last  = last_i;
    push_ent.nbits = NW'(fill) + NW'(1);
  end

  huffman_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Shift register and fill count; a push restarts the next word.
  always_ff @(posedge clk_i) begin
    if (rst_i || push) begin
      sreg <= '0;
      fill <= '0;
    end else if (accept) begin
      sreg <= wnext;
      fill <= fill + FW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: DRAIN exits as soon as the FIFO is (or is about to be) empty
  // so done_o rises the cycle after the final pop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = last_i ? DRAIN : PACK;
      PACK:       if (accept && last_i) state_nxt = DRAIN;
      DRAIN:      if (fifo_empty || (fifo_count == (AW+1)'(1) && pop)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs: handshake, status, and head word zeroed while nothing is valid.
  always_comb begin
    ready_o      = !rst_i && (state != DRAIN) && !fifo_full;
    busy_o       = (state == PACK) || (state == DRAIN);
    done_o       = (state == DONE);
    word_valid_o = !fifo_empty;
    word_o       = fifo_empty ? '0   : head_ent.word;
    word_last_o  = fifo_empty ? 1'b0 : head_ent.last;
    word_nbits_o = fifo_empty ? '0   : head_ent.nbits;
  end

`ifdef HUFF_PACK_STATS_EN
  // Accepted-bit counter; the first bit of a new stream restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_bits_o <= '0;
    end else if (accept) begin
      if (state == IDLE || state == DONE) total_bits_o <= CNT_WIDTH'(1);
      else if (total_bits_o != '1)        total_bits_o <= total_bits_o + CNT_WIDTH'(1);
    end
  end
`else
  // Counter width only matters when statistics are enabled.
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: table-driven streams, hand-written corner
// sequences, and randomized streams checked against a bit-queue model.
module tb_huffman_bit_packer;
  import huffman_pkg::*;

  localparam int BW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 16;
  localparam int NW = $clog2(BW + 1);

  logic clk = 1'b0;
  logic rst, bit_valid, bit_in, last, word_ready;
  logic ready, word_valid, word_last, busy, done;
  logic [BW-1:0] word;
  logic [NW-1:0] word_nbits;
`ifdef HUFF_PACK_STATS_EN
  logic [CW-1:0] total_bits;
`endif

  always #5 clk = ~clk;

  huffman_bit_packer #(.BIT_WIDTH(BW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bit_valid_i  (bit_valid),
    .bit_i        (bit_in),
    .last_i       (last),
    .ready_o      (ready),
    .word_valid_o (word_valid),
    .word_o       (word),
    .word_last_o  (word_last),
    .word_nbits_o (word_nbits),
    .word_ready_i (word_ready),
    .busy_o       (busy),
    .done_o       (done)
`ifdef HUFF_PACK_STATS_EN
    ,
    .total_bits_o (total_bits)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  pack_entry_t expq[$];
  pack_entry_t got_q[$];
  bit          bitq[$];
  logic        accepted;

  typedef struct {
    logic [31:0]      bits;
    int               len;
    int               nw;
    logic [2:0][7:0]  w;
    logic [2:0][3:0]  nb;
    logic [2:0]       lst;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: accepted bits collect in a queue; a word is formed when
  // BW bits have arrived or the stream ends. Popped words must match in order.
  task automatic monitor();
    pack_entry_t g;
    pack_entry_t e;
    accepted = 1'b0;
    if (rst) begin
      bitq.delete();
      expq.delete();
    end else begin
      if (word_valid && word_ready) begin
        g.word = word; g.last = word_last; g.nbits = word_nbits;
        got_q.push_back(g);
        chk("model_has_word", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("model_word", g.word, e.word);
          chk("model_last", g.last, e.last);
          chk("model_nbits", g.nbits, e.nbits);
        end
      end else if (!word_valid) begin
        chk("gated_outputs", {word, word_last, word_nbits}, 0);
      end
      if (bit_valid && ready) begin
        accepted = 1'b1;
        bitq.push_back(bit_in);
        if (bitq.size() == BW || last) begin
          e.word = '0;
          for (int k = 0; k < bitq.size(); k++) e.word[BW-1-k] = bitq[k];
          e.last  = last;
          e.nbits = NW'(bitq.size());
          expq.push_back(e);
          bitq.delete();
        end
      end
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic l);
    int guard;
    guard = 0;
    bit_valid = 1'b1; bit_in = b; last = l;
    do begin
      tick();
      guard++;
    end while (!accepted && guard < 100);
    if (!accepted) chk("bit_accepted", accepted, 1);
    bit_valid = 1'b0; last = 1'b0;
  endtask

  task automatic send_stream(input logic [31:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(bits[i], i == 0);
  endtask

  task automatic wait_done(input int max);
    int g;
    g = 0;
    while (!done && g < max) begin
      tick();
      g++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic set_vec(input int i, input logic [31:0] bits, input int len, input int nw,
                         input logic [7:0] w0, input int nb0, input logic l0,
                         input logic [7:0] w1, input int nb1, input logic l1,
                         input logic [7:0] w2, input int nb2, input logic l2);
    tbl[i].bits = bits; tbl[i].len = len; tbl[i].nw = nw;
    tbl[i].w[0] = w0; tbl[i].nb[0] = 4'(nb0); tbl[i].lst[0] = l0;
    tbl[i].w[1] = w1; tbl[i].nb[1] = 4'(nb1); tbl[i].lst[1] = l1;
    tbl[i].w[2] = w2; tbl[i].nb[2] = 4'(nb2); tbl[i].lst[2] = l2;
  endtask

  initial begin
    int acc;
    int len;
    set_vec(0, 32'h7FD,   11, 2, 8'hFF, 8, 0, 8'hA0, 3, 1, 8'h00, 0, 0);
    set_vec(1, 32'h1,      1, 1, 8'h80, 1, 1, 8'h00, 0, 0, 8'h00, 0, 0);
    set_vec(2, 32'h3CC3,  16, 2, 8'h3C, 8, 0, 8'hC3, 8, 1, 8'h00, 0, 0);
    set_vec(3, 32'h552AE, 19, 3, 8'hAA, 8, 0, 8'h55, 8, 0, 8'hC0, 3, 1);
    set_vec(4, 32'h66,     7, 1, 8'hCC, 7, 1, 8'h00, 0, 0, 8'h00, 0, 0);

    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; last = 1'b0; word_ready = 1'b1;
    @(posedge clk); #1;
    tick(); tick();
    chk("ready_in_reset", ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word", word, 0);
    chk("rst_last", word_last, 0);
    chk("rst_nbits", word_nbits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef HUFF_PACK_STATS_EN
    chk("rst_total_bits", total_bits, 0);
`endif

    // last_i without bit_valid_i in IDLE is ignored.
    got_q.delete();
    last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_last_valid", word_valid, 0);
      chk("idle_last_done", done, 0);
      chk("idle_last_busy", busy, 0);
    end
    last = 1'b0;
    chk("idle_last_words", got_q.size(), 0);

    // Single full word 0xB2; done_o two cycles after the final bit.
    got_q.delete();
    for (int i = 7; i >= 1; i--) send_bit(1'((8'hB2 >> i) & 8'h1), 1'b0);
    send_bit(1'b0, 1'b1);
    chk("b2_done_t1", done, 0);
    chk("b2_busy_t1", busy, 1);
    chk("b2_valid_t1", word_valid, 1);
    tick();
    chk("b2_done_t2", done, 1);
    chk("b2_busy_t2", busy, 0);
    chk("b2_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("b2_word", got_q[0].word, 8'hB2);
      chk("b2_nbits", got_q[0].nbits, 8);
      chk("b2_last", got_q[0].last, 1);
    end

    // Table-driven streams.
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      word_ready = 1'b1;
      send_stream(tbl[v].bits, tbl[v].len);
      wait_done(40);
      chk("tbl_count", got_q.size(), tbl[v].nw);
      for (int j = 0; j < tbl[v].nw && j < got_q.size(); j++) begin
        chk("tbl_word", got_q[j].word, tbl[v].w[j]);
        chk("tbl_nbits", got_q[j].nbits, tbl[v].nb[j]);
        chk("tbl_last", got_q[j].last, tbl[v].lst[j]);
      end
`ifdef HUFF_PACK_STATS_EN
      if (tbl[v].len == 19) chk("stats_total_bits", total_bits, 19);
`endif
    end

    // Backpressure: 4-word FIFO fills after 32 bits.
    got_q.delete();
    word_ready = 1'b0;
    bit_valid = 1'b1; last = 1'b0;
    acc = 0;
    for (int c = 0; c < 45; c++) begin
      bit_in = (acc % 3 == 0);
      tick();
      if (accepted) acc++;
    end
    chk("full_accepted", acc, 32);
    chk("full_ready", ready, 0);
    chk("full_valid", word_valid, 1);
    bit_valid = 1'b0;
    word_ready = 1'b1;
    for (int i = 32; i < 40; i++) send_bit(i % 3 == 0, i == 39);
    wait_done(60);
    chk("full_words_out", got_q.size(), 5);
    if (got_q.size() == 5) begin
      chk("full_w0", got_q[0].word, 8'h92);
      chk("full_w4_last", got_q[4].last, 1);
    end

    // Reset mid-stream discards the partial word and the FIFO.
    got_q.delete();
    word_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_bit(i[0], 1'b0);
    chk("pre_rst_valid", word_valid, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", word_valid, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0;
    word_ready = 1'b1;
    send_stream(32'h5A, 8);
    wait_done(40);
    chk("rst_5a_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("rst_5a_word", got_q[0].word, 8'h5A);
      chk("rst_5a_last", got_q[0].last, 1);
      chk("rst_5a_nbits", got_q[0].nbits, 8);
    end

    // Randomized streams with gaps and consumer stalls.
    for (int s = 0; s < 30; s++) begin
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        int guard;
        guard = 0;
        bit_in = 1'($urandom);
        last = (i == len - 1);
        do begin
          bit_valid = ($urandom % 4 != 0);
          word_ready = ($urandom % 10 < 6);
          tick();
          guard++;
        end while (!accepted && guard < 200);
        if (!accepted) chk("rand_bit_accepted", accepted, 1);
      end
      bit_valid = 1'b0; last = 1'b0; word_ready = 1'b1;
      wait_done(60);
      chk("rand_drained", expq.size(), 0);
      chk("rand_no_residue", bitq.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
